// File: rtl/timer_nbit_v2_pkg.sv
// -----------------------------------------------------------------------------
// pkg_tmr_v2
// Shared types for the second-generation N-bit timer.
//   tmr_mode_e  : counting direction scheme (UP, DOWN, UPDOWN)
//   tmr_state_e : run state of the timer FSM (IDLE, RUN)
//   decode_mode : maps the raw 2-bit mode field onto tmr_mode_e; the unused
//                 encoding 2'b11 behaves as UP.
// No ports (package).
// -----------------------------------------------------------------------------
package pkg_tmr_v2;

  typedef enum logic [1:0] {
    UP     = 2'b00,
    DOWN   = 2'b01,
    UPDOWN = 2'b10
  } tmr_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_e;

  function automatic tmr_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return DOWN;
      2'b10:   return UPDOWN;
      default: return UP;
    endcase
  endfunction

endpackage

// File: rtl/timer_nbit_v2_if.sv
// -----------------------------------------------------------------------------
// timer_nbit_v2_if
// Control/status bundle between the SFR wrapper (master) and the timer
// (slave).
//
// Signalling: there is no valid/ready pair on this bundle. start, stop,
// sw_rst and ld are single-cycle command pulses sampled on every pwm_clk
// edge where clk_en=1; the timer accepts them unconditionally in that cycle.
// flag_clr bits are sampled on every edge regardless of clk_en. All other
// master outputs are levels. match_event/ovf_event are one-cycle pulses;
// match_flag/ovf_flag are sticky until cleared.
//
// Master -> slave : clk_en, tmr_on, start, stop, sw_rst, ld, ld_val, mode,
//                   one_shot, period, psc, match_val, match_en, flag_clr
// Slave -> master : tmr_value, running, dir, match_event, ovf_event,
//                   match_flag, ovf_flag, dbg_state, dbg_psc_cnt
// -----------------------------------------------------------------------------
interface timer_nbit_v2_if #(
  parameter int N      = 32,
  parameter int NUM_CH = 4,
  parameter int PSC_W  = 8
);
  import pkg_tmr_v2::*;

  logic                  clk_en;
  logic                  tmr_on;
  logic                  start;
  logic                  stop;
  logic                  sw_rst;
  logic                  ld;
  logic [N-1:0]          ld_val;
  logic [1:0]            mode;
  logic                  one_shot;
  logic [N-1:0]          period;
  logic [PSC_W-1:0]      psc;
  logic [NUM_CH*N-1:0]   match_val;
  logic [NUM_CH-1:0]     match_en;
  logic [NUM_CH:0]       flag_clr;

  logic [N-1:0]          tmr_value;
  logic                  running;
  logic                  dir;
  logic [NUM_CH-1:0]     match_event;
  logic                  ovf_event;
  logic [NUM_CH-1:0]     match_flag;
  logic                  ovf_flag;

  // Observation points for checkers: FSM state and prescaler count.
  tmr_state_e            dbg_state;
  logic [PSC_W-1:0]      dbg_psc_cnt;

  modport master (
    output clk_en, tmr_on, start, stop, sw_rst, ld, ld_val, mode, one_shot,
           period, psc, match_val, match_en, flag_clr,
    input  tmr_value, running, dir, match_event, ovf_event, match_flag,
           ovf_flag, dbg_state, dbg_psc_cnt
  );

  modport slave (
    input  clk_en, tmr_on, start, stop, sw_rst, ld, ld_val, mode, one_shot,
           period, psc, match_val, match_en, flag_clr,
    output tmr_value, running, dir, match_event, ovf_event, match_flag,
           ovf_flag, dbg_state, dbg_psc_cnt
  );

endinterface

// File: rtl/timer_nbit_v2_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides enabled cycles by (i_psc+1). o_tick is high in every enabled cycle
// where the count has reached i_psc; the count then wraps to 0. The count
// holds while i_en is low and i_clr forces it back to 0.
//
// Ports:
//   pwm_clk    in   timer clock
//   sys_rst_n  in   asynchronous active-low reset
//   i_en       in   advance the prescaler this cycle
//   i_clr      in   synchronous clear (wins over i_en)
//   i_psc      in   PSC_W  divide value minus one
//   o_tick     out  counter step strobe (combinational)
//   o_psc_cnt  out  PSC_W  current prescaler count
// -----------------------------------------------------------------------------
module timer_prescaler #(
  parameter int PSC_W = 8
) (
  input  logic             pwm_clk,
  input  logic             sys_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [PSC_W-1:0] i_psc,
  output logic             o_tick,
  output logic [PSC_W-1:0] o_psc_cnt
);

  logic [PSC_W-1:0] r_cnt;

  assign o_tick    = i_en & (r_cnt == i_psc);
  assign o_psc_cnt = r_cnt;

  always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      // If psc was lowered below the current count, the count runs on and
      // wraps through zero before it can match again.
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_nbit_v2.sv
// -----------------------------------------------------------------------------
// timer_nbit_v2
// Second-generation N-bit timer: prescaler, period register, up / down /
// up-down counting, one-shot mode, NUM_CH match channels and sticky event
// flags with software clear.
//
// Ports:
//   pwm_clk    in   timer clock
//   sys_rst_n  in   asynchronous active-low reset
//   bus        slave modport of timer_nbit_v2_if (all control and status)
//
// Per enabled edge the counter obeys sw_rst > ld > tick. The run state is
// handled independently: stop / tmr_on=0 / one-shot end leave RUN, start
// enters RUN from IDLE, and stop beats start. A stop, sw_rst or ld in a cycle
// suppresses the count in that same cycle.
// -----------------------------------------------------------------------------
module timer_nbit_v2
  import pkg_tmr_v2::*;
#(
  parameter int N      = 32,
  parameter int NUM_CH = 4,
  parameter int PSC_W  = 8
) (
  input  logic            pwm_clk,
  input  logic            sys_rst_n,
  timer_nbit_v2_if.slave  bus
);

  tmr_state_e        r_state;
  logic [N-1:0]      r_value;
  logic              r_dir;
  logic              r_ovf_event;
  logic              r_ovf_flag;

  tmr_mode_e         w_mode;
  logic              w_run_en;
  logic              w_psc_clr;
  logic              w_tick;
  logic [PSC_W-1:0]  w_psc_cnt;
  logic [N-1:0]      w_next;
  logic              w_dir_next;
  logic              w_ovf;
  logic [NUM_CH-1:0] w_match_event;
  logic [NUM_CH-1:0] w_match_flag;

  assign w_mode = decode_mode(bus.mode);

  // Counting is only possible while running; a same-cycle stop, sw_rst or ld
  // takes the cycle instead of the count.
  assign w_run_en  = bus.clk_en & bus.tmr_on & (r_state == RUN) &
                     ~bus.stop & ~bus.sw_rst & ~bus.ld;
  assign w_psc_clr = bus.clk_en & (bus.sw_rst | bus.ld);

  timer_prescaler #(.PSC_W(PSC_W)) u_psc (
    .pwm_clk   (pwm_clk),
    .sys_rst_n (sys_rst_n),
    .i_en      (w_run_en),
    .i_clr     (w_psc_clr),
    .i_psc     (bus.psc),
    .o_tick    (w_tick),
    .o_psc_cnt (w_psc_cnt)
  );

  // Value the counter takes if this cycle ticks, and whether that step is a
  // period end. All arithmetic wraps modulo 2^N.
  always_comb begin
    w_next     = r_value;
    w_dir_next = r_dir;
    w_ovf      = 1'b0;
    case (w_mode)
      DOWN: begin
        w_dir_next = 1'b1;
        if (r_value == '0) begin
          w_next = bus.period;
          w_ovf  = 1'b1;
        end else begin
          w_next = r_value - 1'b1;
        end
      end
      UPDOWN: begin
        if (bus.period == '0) begin
          // Degenerate period: parked at zero, every tick is a period end.
          w_next     = '0;
          w_dir_next = 1'b0;
        end else if ((!r_dir && (r_value == bus.period)) ||
                     (r_dir && (r_value != '0))) begin
          w_next     = r_value - 1'b1;
          w_dir_next = 1'b1;
        end else begin
          // Includes turning around at zero and the climb past a lowered
          // period, which wraps through 2^N-1 to zero.
          w_next     = r_value + 1'b1;
          w_dir_next = 1'b0;
        end
        w_ovf = (w_next == '0);
      end
      default: begin
        w_dir_next = 1'b0;
        // A value above period runs to all-ones and wraps naturally.
        if ((r_value == bus.period) || (&r_value)) begin
          w_next = '0;
          w_ovf  = 1'b1;
        end else begin
          w_next = r_value + 1'b1;
        end
      end
    endcase
  end

  // Run-state FSM together with the counter and direction registers.
  always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_value <= '0;
      r_dir   <= 1'b0;
    end else if (bus.clk_en) begin
      case (r_state)
        IDLE: begin
          if (bus.tmr_on && bus.start && !bus.stop) r_state <= RUN;
        end
        RUN: begin
          if (!bus.tmr_on || bus.stop || (w_tick && w_ovf && bus.one_shot))
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (bus.sw_rst) begin
        r_value <= (w_mode == DOWN) ? bus.period : '0;
        r_dir   <= (w_mode == DOWN);
      end else if (bus.ld) begin
        r_value <= bus.ld_val;
      end else if (w_tick) begin
        r_value <= w_next;
        r_dir   <= w_dir_next;
      end
    end
  end

  // Events are registered so they line up with the new counter value; flags
  // pick them up one cycle later. These registers run regardless of clk_en
  // (the tick is already gated), so events stay single-cycle and flag clear
  // works while frozen. A set beats a same-cycle clear.
  always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ovf_event <= 1'b0;
      r_ovf_flag  <= 1'b0;
    end else begin
      r_ovf_event <= w_tick & w_ovf;
      r_ovf_flag  <= r_ovf_event | (r_ovf_flag & ~bus.flag_clr[NUM_CH]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_hit;
    logic r_event;
    logic r_flag;

    assign w_hit = bus.match_en[g] & (w_next == bus.match_val[g*N +: N]);

    always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_event <= 1'b0;
        r_flag  <= 1'b0;
      end else begin
        r_event <= w_tick & w_hit;
        r_flag  <= r_event | (r_flag & ~bus.flag_clr[g]);
      end
    end

    assign w_match_event[g] = r_event;
    assign w_match_flag[g]  = r_flag;
  end

  assign bus.tmr_value   = r_value;
  assign bus.running     = (r_state == RUN);
  assign bus.dir         = r_dir;
  assign bus.match_event = w_match_event;
  assign bus.ovf_event   = r_ovf_event;
  assign bus.match_flag  = w_match_flag;
  assign bus.ovf_flag    = r_ovf_flag;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_psc_cnt = w_psc_cnt;

endmodule

// File: tb/tb_timer_nbit_v2.sv
// -----------------------------------------------------------------------------
// tb_timer_nbit_v2
// Directed scenarios for timer_nbit_v2 followed by a randomized phase checked
// cycle by cycle against a behavioural model of the timer rules.
// -----------------------------------------------------------------------------
module tb_timer_nbit_v2;

  localparam int N      = 32;
  localparam int NUM_CH = 4;
  localparam int PSC_W  = 8;
  localparam int FW     = NUM_CH + 1;
  localparam logic [N-1:0] MAXV = '1;

  // ---------------- clock / reset ----------------
  logic pwm_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 pwm_clk = ~pwm_clk;

  timer_nbit_v2_if #(.N(N), .NUM_CH(NUM_CH), .PSC_W(PSC_W)) bus ();

  timer_nbit_v2 #(.N(N), .NUM_CH(NUM_CH), .PSC_W(PSC_W)) dut (
    .pwm_clk   (pwm_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];

  // Reference model state (expected outputs after the next edge)
  bit                m_run;
  bit                m_dir;
  bit                m_oev;
  bit                m_oflag;
  logic [N-1:0]      m_value;
  int unsigned       m_psc;
  logic [NUM_CH-1:0] m_mev;
  logic [NUM_CH-1:0] m_mflag;

  int ud_v[7];
  int ud_d[7];
  int ud_o[7];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge pwm_clk);
    #1;
  endtask

  task automatic set_defaults();
    bus.clk_en    = 1'b1;
    bus.tmr_on    = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.sw_rst    = 1'b0;
    bus.ld        = 1'b0;
    bus.ld_val    = '0;
    bus.mode      = 2'b00;
    bus.one_shot  = 1'b0;
    bus.period    = '0;
    bus.psc       = '0;
    bus.match_val = '0;
    bus.match_en  = '0;
    bus.flag_clr  = '0;
  endtask

  task automatic do_reset();
    set_defaults();
    sys_rst_n = 1'b0;
    m_run = 0; m_dir = 0; m_oev = 0; m_oflag = 0;
    m_value = '0; m_psc = 0; m_mev = '0; m_mflag = '0;
    step();
    step();
    sys_rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_value"},   bus.tmr_value,   0);
    check({tag, "_running"}, bus.running,     0);
    check({tag, "_dir"},     bus.dir,         0);
    check({tag, "_mev"},     bus.match_event, 0);
    check({tag, "_oev"},     bus.ovf_event,   0);
    check({tag, "_mflag"},   bus.match_flag,  0);
    check({tag, "_oflag"},   bus.ovf_flag,    0);
  endtask

  // ---------------- behavioural model ----------------
  // Applies the timer rules to the inputs presently driven and predicts the
  // outputs after the coming edge.
  task automatic model_step();
    int unsigned md;
    bit en, tick, ovf, desc, nd;
    logic [N-1:0] nv, p;
    // flags absorb the events visible now; a set beats a clear
    m_oflag = m_oev | (m_oflag & ~bus.flag_clr[NUM_CH]);
    m_mflag = m_mev | (m_mflag & ~bus.flag_clr[NUM_CH-1:0]);
    m_oev = 0;
    m_mev = '0;
    if (bus.clk_en) begin
      md   = (bus.mode == 2'b11) ? 0 : int'(bus.mode);
      p    = bus.period;
      en   = m_run && bus.tmr_on && !bus.stop && !bus.sw_rst && !bus.ld;
      tick = en && (m_psc == int'(bus.psc));
      nv = m_value; nd = m_dir; ovf = 0;
      if (tick) begin
        if (md == 0) begin
          ovf = (m_value == p) || (m_value == MAXV);
          nv  = ovf ? '0 : m_value + 1;
          nd  = 0;
        end else if (md == 1) begin
          ovf = (m_value == 0);
          nv  = ovf ? p : m_value - 1;
          nd  = 1;
        end else begin
          if (p == 0) begin
            nv = '0;
            nd = 0;
          end else begin
            desc = m_dir ? (m_value != 0) : (m_value == p);
            nv   = desc ? m_value - 1 : m_value + 1;
            nd   = desc;
          end
          ovf = (nv == 0);
        end
        m_oev = ovf;
        for (int i = 0; i < NUM_CH; i++)
          m_mev[i] = bus.match_en[i] && (nv == bus.match_val[i*N +: N]);
      end
      if (bus.sw_rst || bus.ld || tick) m_psc = 0;
      else if (en)                      m_psc = (m_psc + 1) % 256;
      if (bus.sw_rst) begin
        m_value = (md == 1) ? p : '0;
        m_dir   = (md == 1);
      end else if (bus.ld) begin
        m_value = bus.ld_val;
      end else if (tick) begin
        m_value = nv;
        m_dir   = nd;
      end
      if (m_run) begin
        if (!bus.tmr_on || bus.stop || (tick && ovf && bus.one_shot)) m_run = 0;
      end else if (bus.tmr_on && bus.start && !bus.stop) begin
        m_run = 1;
      end
    end
    exp_q.push_back(m_value);
  endtask

  task automatic check_model();
    logic [N-1:0] ev;
    if (exp_q.size() == 0) begin
      check("rnd_queue_empty", 1, 0);
    end else begin
      ev = exp_q.pop_front();
      check("rnd_value",   bus.tmr_value,   ev);
      check("rnd_running", bus.running,     m_run);
      check("rnd_dir",     bus.dir,         m_dir);
      check("rnd_oev",     bus.ovf_event,   m_oev);
      check("rnd_mev",     bus.match_event, m_mev);
      check("rnd_oflag",   bus.ovf_flag,    m_oflag);
      check("rnd_mflag",   bus.match_flag,  m_mflag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mcount;
    ud_v = '{1, 2, 3, 2, 1, 0, 1};
    ud_d = '{0, 0, 0, 1, 1, 1, 0};
    ud_o = '{0, 0, 0, 0, 0, 1, 0};

    // Reset state
    do_reset();
    check_outputs_zero("reset");

    // Up count, period 4, no prescale
    bus.period = 4;
    pulse_start();
    check("t1_running", bus.running, 1);
    check("t1_v0", bus.tmr_value, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t1_count", bus.tmr_value, i);
      check("t1_no_ovf", bus.ovf_event, 0);
    end
    step();
    check("t1_wrap", bus.tmr_value, 0);
    check("t1_ovf_event", bus.ovf_event, 1);
    check("t1_flag_not_yet", bus.ovf_flag, 0);
    step();
    check("t1_ovf_flag", bus.ovf_flag, 1);
    check("t1_ovf_pulse_end", bus.ovf_event, 0);
    check("t1_after_wrap", bus.tmr_value, 1);

    // Prescaler 2: one step per 3 cycles, one match event for value 2
    do_reset();
    bus.psc = 2;
    bus.period = 10;
    bus.match_val[N-1:0] = 2;
    bus.match_en = 4'b0001;
    pulse_start();
    mcount = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (bus.match_event[0]) mcount++;
      if (c == 2) check("t2_hold", bus.tmr_value, 0);
      if (c == 3) check("t2_first_step", bus.tmr_value, 1);
    end
    check("t2_value", bus.tmr_value, 3);
    check("t2_match_count", mcount, 1);
    check("t2_match_flag", bus.match_flag, 4'b0001);

    // Up-down, period 3
    do_reset();
    bus.mode = 2'b10;
    bus.period = 3;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      step();
      check("t3_value", bus.tmr_value, ud_v[i]);
      check("t3_dir", bus.dir, ud_d[i]);
      check("t3_ovf", bus.ovf_event, ud_o[i]);
    end

    // Down, one-shot, period 2
    do_reset();
    bus.mode = 2'b01;
    bus.one_shot = 1'b1;
    bus.period = 2;
    bus.sw_rst = 1'b1;
    step();
    bus.sw_rst = 1'b0;
    check("t4_swrst_value", bus.tmr_value, 2);
    check("t4_swrst_dir", bus.dir, 1);
    check("t4_swrst_idle", bus.running, 0);
    pulse_start();
    check("t4_start_value", bus.tmr_value, 2);
    step();
    check("t4_v1", bus.tmr_value, 1);
    step();
    check("t4_v0", bus.tmr_value, 0);
    step();
    check("t4_reload", bus.tmr_value, 2);
    check("t4_ovf", bus.ovf_event, 1);
    check("t4_stopped", bus.running, 0);
    step();
    step();
    check("t4_hold_value", bus.tmr_value, 2);
    check("t4_hold_idle", bus.running, 0);

    // Load near the top, load+start together
    do_reset();
    bus.period = 10;
    bus.ld_val = 32'hFFFF_FFFE;
    bus.ld = 1'b1;
    bus.start = 1'b1;
    step();
    bus.ld = 1'b0;
    bus.start = 1'b0;
    check("t5_loaded", bus.tmr_value, 32'hFFFF_FFFE);
    check("t5_running", bus.running, 1);
    step();
    check("t5_max", bus.tmr_value, 32'hFFFF_FFFF);
    check("t5_no_ovf", bus.ovf_event, 0);
    step();
    check("t5_wrap", bus.tmr_value, 0);
    check("t5_ovf", bus.ovf_event, 1);

    // Flag set wins over same-cycle clear, then a lone clear works
    bus.flag_clr[NUM_CH] = 1'b1;
    step();
    check("t6_set_wins", bus.ovf_flag, 1);
    step();
    bus.flag_clr = '0;
    check("t6_cleared", bus.ovf_flag, 0);
    check("t6_value", bus.tmr_value, 2);

    // Stop halts immediately; start+stop together stays stopped
    bus.stop = 1'b1;
    bus.start = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.start = 1'b0;
    check("t7_stop_value", bus.tmr_value, 2);
    check("t7_stop_idle", bus.running, 0);
    step();
    step();
    check("t7_frozen", bus.tmr_value, 2);

    // Restart, then asynchronous reset mid-run
    pulse_start();
    step();
    check("t8_resumed", bus.tmr_value, 3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_outputs_zero("t8_async");

    // Randomized phase against the model
    do_reset();
    for (int blk = 0; blk < 24; blk++) begin
      bus.mode     = 2'($urandom_range(0, 3));
      bus.period   = N'($urandom_range(0, 6));
      bus.psc      = PSC_W'($urandom_range(0, 2));
      bus.one_shot = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_CH; i++)
        bus.match_val[i*N +: N] = N'($urandom_range(0, 6));
      bus.match_en = NUM_CH'($urandom_range(0, 15));
      for (int c = 0; c < 64; c++) begin
        bus.sw_rst   = (c == 0) || ($urandom_range(0, 63) == 0);
        bus.start    = ($urandom_range(0, 5) == 0);
        bus.stop     = ($urandom_range(0, 40) == 0);
        bus.ld       = ($urandom_range(0, 50) == 0);
        bus.ld_val   = ($urandom_range(0, 3) == 0) ? MAXV - N'($urandom_range(0, 2))
                                                   : N'($urandom_range(0, 8));
        bus.clk_en   = ($urandom_range(0, 7) != 0);
        bus.tmr_on   = ($urandom_range(0, 30) != 0);
        bus.flag_clr = ($urandom_range(0, 3) == 0) ? FW'($urandom_range(0, 31)) : '0;
        model_step();
        step();
        check_model();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
